// File: rtl/id_ex_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Purpose  : ID/EX operand stage. Holds one decoded instruction. At accept it
//             resolves the source operands, taking EX/MEM first, then WB, then
//             the register file. Register x0 always reads as zero. The
//             registered outputs drive the ALU directly.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n              clock; synchronous active-low reset
//    in_valid / in_ready     decode handshake. in_ready is low during reset,
//                            flush, a load-use hazard, or a blocked output.
//    dec_*                   decoded fields and register-file read data
//    exm_*                   EX/MEM destination, ALU result, load-pending flag
//    wb_*                    writeback port (forwarding and held refresh)
//    flush                   drops the held entry and the incoming instruction
//    out_valid / out_ready   downstream handshake
//    alu_rs1, alu_rs2,
//    alu_op                  ALU operand and opcode inputs
//    out_rd_addr, out_rd_we  destination of the held instruction
//    out_store_data          resolved rs2, whether or not an immediate is used
//    stall_cnt               saturating count of in_valid && !in_ready cycles
// ============================================================================
module id_ex_operand_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  dec_op,
    input  logic [4:0]  dec_rs1_addr,
    input  logic [4:0]  dec_rs2_addr,
    input  logic [4:0]  dec_rd_addr,
    input  logic        dec_rd_we,
    input  logic        dec_use_imm,
    input  logic [31:0] dec_rs1_data,
    input  logic [31:0] dec_rs2_data,
    input  logic [31:0] dec_imm,
    input  logic        exm_rd_we,
    input  logic [4:0]  exm_rd_addr,
    input  logic [31:0] exm_result,
    input  logic        exm_load_pending,
    input  logic        wb_rd_we,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [3:0]  alu_op,
    output logic [4:0]  out_rd_addr,
    output logic        out_rd_we,
    output logic [31:0] out_store_data,
    output logic [15:0] stall_cnt
);

    localparam logic [4:0]  c_X0        = 5'd0;
    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Held entry
    // ------------------------------------------------------------------------
    logic        r_valid;
    logic [31:0] r_alu_rs1;
    logic [31:0] r_alu_rs2;
    logic [31:0] r_store_data;
    logic [3:0]  r_alu_op;
    logic [4:0]  r_rd_addr;
    logic        r_rd_we;
    // Source addresses of the held entry. They are kept so that a WB write
    // arriving during a downstream stall can still update the operands.
    logic [4:0]  r_rs1_addr;
    logic [4:0]  r_rs2_addr;
    logic        r_use_imm;
    logic [15:0] r_stall_cnt;

    // ------------------------------------------------------------------------
    // Handshake and hazard
    // ------------------------------------------------------------------------
    logic        w_exm_live;
    logic        w_hazard;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_hold;
    logic        w_stall_event;

    assign w_exm_live = exm_rd_we && (exm_rd_addr != c_X0);

    // The result of a load in EX/MEM is not available yet, so a matching
    // source cannot be forwarded. rs2 is always checked, even when an
    // immediate replaces it on the ALU side, because stores need it.
    assign w_hazard = in_valid && exm_load_pending && w_exm_live &&
                      ((exm_rd_addr == dec_rs1_addr) ||
                       (exm_rd_addr == dec_rs2_addr));

    assign w_in_ready    = rst_n && (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept      = in_valid && w_in_ready;
    assign w_hold        = r_valid && !out_ready;
    assign w_stall_event = in_valid && !w_in_ready;

    // ------------------------------------------------------------------------
    // Operand resolution at accept
    // ------------------------------------------------------------------------
    logic [31:0] w_rs1_res;
    logic [31:0] w_rs2_res;

    always_comb begin
        w_rs1_res = dec_rs1_data;
        if (dec_rs1_addr == c_X0) begin
            w_rs1_res = 32'h0;
        end else if (w_exm_live && (exm_rd_addr == dec_rs1_addr)) begin
            w_rs1_res = exm_result;
        end else if (wb_rd_we && (wb_rd_addr == dec_rs1_addr)) begin
            w_rs1_res = wb_data;
        end
    end

    always_comb begin
        w_rs2_res = dec_rs2_data;
        if (dec_rs2_addr == c_X0) begin
            w_rs2_res = 32'h0;
        end else if (w_exm_live && (exm_rd_addr == dec_rs2_addr)) begin
            w_rs2_res = exm_result;
        end else if (wb_rd_we && (wb_rd_addr == dec_rs2_addr)) begin
            w_rs2_res = wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Refresh of the held entry from WB during a downstream stall
    // ------------------------------------------------------------------------
    logic w_wb_live;
    logic w_wb_hit_rs1;
    logic w_wb_hit_rs2;

    assign w_wb_live    = wb_rd_we && (wb_rd_addr != c_X0);
    assign w_wb_hit_rs1 = w_hold && w_wb_live && (wb_rd_addr == r_rs1_addr);
    assign w_wb_hit_rs2 = w_hold && w_wb_live && (wb_rd_addr == r_rs2_addr);

    // ------------------------------------------------------------------------
    // Held entry register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_alu_rs1    <= 32'h0;
            r_alu_rs2    <= 32'h0;
            r_store_data <= 32'h0;
            r_alu_op     <= 4'h0;
            r_rd_addr    <= 5'd0;
            r_rd_we      <= 1'b0;
            r_rs1_addr   <= 5'd0;
            r_rs2_addr   <= 5'd0;
            r_use_imm    <= 1'b0;
        end else if (flush) begin
            // Flush drops the entry but leaves the data fields unchanged.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_alu_rs1    <= w_rs1_res;
            r_alu_rs2    <= dec_use_imm ? dec_imm : w_rs2_res;
            r_store_data <= w_rs2_res;
            r_alu_op     <= dec_op;
            r_rd_addr    <= dec_rd_addr;
            r_rd_we      <= dec_rd_we && (dec_rd_addr != c_X0);
            r_rs1_addr   <= dec_rs1_addr;
            r_rs2_addr   <= dec_rs2_addr;
            r_use_imm    <= dec_use_imm;
        end else if (w_hold) begin
            if (w_wb_hit_rs1) begin
                r_alu_rs1 <= wb_data;
            end
            if (w_wb_hit_rs2) begin
                r_store_data <= wb_data;
                if (!r_use_imm) begin
                    r_alu_rs2 <= wb_data;
                end
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stall counter, saturating
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_event && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready       = w_in_ready;
    assign out_valid      = r_valid;
    assign alu_rs1        = r_alu_rs1;
    assign alu_rs2        = r_alu_rs2;
    assign alu_op         = r_alu_op;
    assign out_rd_addr    = r_rd_addr;
    assign out_rd_we      = r_rd_we;
    assign out_store_data = r_store_data;
    assign stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Purpose  : Self-checking bench for id_ex_operand_stage. It runs directed
//             scenarios and then a randomized run. Both are checked against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  dec_op;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic        dec_rd_we, dec_use_imm;
    logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
    logic        exm_rd_we;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_result;
    logic        exm_load_pending;
    logic        wb_rd_we;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_rs1, alu_rs2, out_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dec_op(dec_op), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rd_addr(dec_rd_addr), .dec_rd_we(dec_rd_we), .dec_use_imm(dec_use_imm),
        .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
        .exm_rd_we(exm_rd_we), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .exm_load_pending(exm_load_pending), .wb_rd_we(wb_rd_we),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_op(alu_op), .out_rd_addr(out_rd_addr),
        .out_rd_we(out_rd_we), .out_store_data(out_store_data), .stall_cnt(stall_cnt)
    );

    // ------------------------------------------------------------------------
    // Reference model: one transaction slot plus a saturating stall counter
    // ------------------------------------------------------------------------
    logic        m_valid = 1'b0;
    logic [31:0] m_rs1 = '0, m_rs2 = '0, m_sd = '0;
    logic [3:0]  m_op = '0;
    logic [4:0]  m_rd = '0, m_a1 = '0, m_a2 = '0;
    logic        m_we = 1'b0, m_imm = 1'b0;
    int          m_stall = 0;

    function automatic logic mdl_ready();
        logic load_use;
        load_use = in_valid && exm_load_pending && exm_rd_we && (exm_rd_addr != 0) &&
                   (exm_rd_addr == dec_rs1_addr || exm_rd_addr == dec_rs2_addr);
        return rst_n && (!m_valid || out_ready) && !load_use && !flush;
    endfunction

    function automatic logic [31:0] mdl_operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (exm_rd_we && exm_rd_addr == a) return exm_result;
        if (wb_rd_we && wb_rd_addr == a) return wb_data;
        return rf;
    endfunction

    // Advance the model by one clock edge, using the inputs as they stand now.
    task automatic mdl_edge();
        logic rdy;
        rdy = mdl_ready();
        if (!rst_n) begin
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_sd = 0; m_op = 0;
            m_rd = 0; m_we = 0; m_a1 = 0; m_a2 = 0; m_imm = 0; m_stall = 0;
        end else begin
            if (in_valid && !rdy && m_stall < 65535) m_stall++;
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1;
                m_rs1 = mdl_operand(dec_rs1_addr, dec_rs1_data);
                m_sd  = mdl_operand(dec_rs2_addr, dec_rs2_data);
                m_rs2 = dec_use_imm ? dec_imm : m_sd;
                m_op = dec_op; m_rd = dec_rd_addr; m_we = dec_rd_we && dec_rd_addr != 0;
                m_a1 = dec_rs1_addr; m_a2 = dec_rs2_addr; m_imm = dec_use_imm;
            end else if (m_valid && !out_ready) begin
                if (wb_rd_we && wb_rd_addr != 0 && wb_rd_addr == m_a1) m_rs1 = wb_data;
                if (wb_rd_we && wb_rd_addr != 0 && wb_rd_addr == m_a2) begin
                    m_sd = wb_data;
                    if (!m_imm) m_rs2 = wb_data;
                end
            end else if (out_ready) m_valid = 0;
        end
    endtask

    // One clock: update the model, take the edge, and return 1ns after it.
    task automatic cyc();
        mdl_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1; in_valid = 0; flush = 0; out_ready = 1;
        dec_op = 0; dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
        dec_rd_we = 0; dec_use_imm = 0; dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0;
        exm_rd_we = 0; exm_rd_addr = 0; exm_result = 0; exm_load_pending = 0;
        wb_rd_we = 0; wb_rd_addr = 0; wb_data = 0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        set_idle();
        rst_n = 0; in_valid = 1; dec_op = 4'h5; dec_rd_addr = 5'd3; dec_rd_we = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        cyc(); cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if ({alu_rs1, alu_rs2, out_store_data} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h %h %h exp 0", alu_rs1, alu_rs2, out_store_data); end
        n_cmp++; if ({alu_op, out_rd_addr, out_rd_we} !== 10'h0) begin n_fail++; $display("FAIL reset_ctrl got op %h rd %h we %b exp 0", alu_op, out_rd_addr, out_rd_we); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        set_idle();
        cyc();
    endtask

    task automatic test_load_use();
        set_idle();
        in_valid = 1; exm_load_pending = 1; exm_rd_we = 1; exm_rd_addr = 5'd7;
        dec_rs1_addr = 5'd1; dec_rs1_data = 32'h1; dec_rs2_addr = 5'd7; dec_rs2_data = 32'hbad;
        dec_op = 4'h2; exm_result = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_ready[%0d] got %b exp 0", i, in_ready); end
            cyc();
        end
        n_cmp++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL load_use_stall got %0d exp 3", stall_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_no_out got %b exp 0", out_valid); end
        exm_load_pending = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release got %b exp 1", in_ready); end
        cyc();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL load_use_accept got %b exp 1", out_valid); end
        n_cmp++; if (out_store_data !== 32'h77) begin n_fail++; $display("FAIL load_use_fwd got %h exp 00000077", out_store_data); end
        n_cmp++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL load_use_stall_hold got %0d exp 3", stall_cnt); end
    endtask

    task automatic test_forward_priority();
        set_idle();
        in_valid = 1; dec_rs1_addr = 5'd5; dec_rs1_data = 32'h5555_0000;
        exm_rd_we = 1; exm_rd_addr = 5'd5; exm_result = 32'h0a17_0000;
        wb_rd_we = 1; wb_rd_addr = 5'd5; wb_data = 32'h1111_1111;
        cyc();
        n_cmp++; if (alu_rs1 !== 32'h0a17_0000) begin n_fail++; $display("FAIL fwd_exm_prio got %h exp 0a170000", alu_rs1); end
        exm_rd_we = 0;
        cyc();
        n_cmp++; if (alu_rs1 !== 32'h1111_1111) begin n_fail++; $display("FAIL fwd_wb got %h exp 11111111", alu_rs1); end
    endtask

    task automatic test_x0_guard();
        set_idle();
        in_valid = 1; dec_rs2_addr = 5'd0; dec_rs2_data = 32'hdead_beef;
        exm_rd_we = 1; exm_rd_addr = 5'd0; exm_result = 32'h1234_5678;
        wb_rd_we = 1; wb_rd_addr = 5'd0; wb_data = 32'h8765_4321;
        dec_rd_addr = 5'd0; dec_rd_we = 1;
        cyc();
        n_cmp++; if (out_store_data !== 32'h0) begin n_fail++; $display("FAIL x0_store got %h exp 0", out_store_data); end
        n_cmp++; if (alu_rs2 !== 32'h0) begin n_fail++; $display("FAIL x0_alu_rs2 got %h exp 0", alu_rs2); end
        n_cmp++; if (out_rd_we !== 1'b0) begin n_fail++; $display("FAIL x0_rd_we got %b exp 0", out_rd_we); end
    endtask

    task automatic test_held_refresh();
        set_idle();
        in_valid = 1; dec_op = 4'h3; dec_rs1_addr = 5'd3; dec_rs1_data = 32'h3333_3333;
        dec_rs2_addr = 5'd4; dec_rs2_data = 32'h4444_4444;
        cyc();
        n_cmp++; if (alu_rs1 !== 32'h3333_3333) begin n_fail++; $display("FAIL held_load got %h exp 33333333", alu_rs1); end
        in_valid = 0; out_ready = 0; wb_rd_we = 1; wb_rd_addr = 5'd3; wb_data = 32'hfa17_0000;
        cyc();
        n_cmp++; if (alu_rs1 !== 32'hfa17_0000) begin n_fail++; $display("FAIL held_rs1 got %h exp fa170000", alu_rs1); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL held_valid got %b exp 1", out_valid); end
        n_cmp++; if (alu_rs2 !== 32'h4444_4444) begin n_fail++; $display("FAIL held_rs2_keep got %h exp 44444444", alu_rs2); end
        wb_rd_addr = 5'd4; wb_data = 32'h5555_aaaa;
        cyc();
        n_cmp++; if ({alu_rs2, out_store_data} !== {2{32'h5555_aaaa}}) begin n_fail++; $display("FAIL held_rs2 got %h %h exp 5555aaaa", alu_rs2, out_store_data); end
    endtask

    task automatic test_flush();
        // Entry from test_held_refresh is still held with alu_op 3.
        set_idle();
        in_valid = 1; out_ready = 1; flush = 1; dec_op = 4'hf; dec_rs1_addr = 5'd9;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", in_ready); end
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        n_cmp++; if (alu_op !== 4'h3) begin n_fail++; $display("FAIL flush_op got %h exp 3", alu_op); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        set_idle();
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            dec_op = 4'(i + 1); dec_rs1_addr = 5'(i + 1); dec_rs1_data = d;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
            cyc();
            n_cmp++; if ({out_valid, alu_op, alu_rs1} !== {1'b1, 4'(i + 1), d}) begin n_fail++; $display("FAIL b2b[%0d] got v%b op %h rs1 %h exp v1 op %h rs1 %h", i, out_valid, alu_op, alu_rs1, 4'(i + 1), d); end
        end
        in_valid = 0;
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n            = ($urandom_range(49, 0) != 0);
            in_valid         = ($urandom_range(3, 0) != 0);
            out_ready        = ($urandom_range(9, 0) < 6);
            flush            = ($urandom_range(19, 0) == 0);
            dec_op           = 4'($urandom);
            dec_rs1_addr     = 5'($urandom_range(7, 0));
            dec_rs2_addr     = 5'($urandom_range(7, 0));
            dec_rd_addr      = 5'($urandom_range(7, 0));
            dec_rd_we        = 1'($urandom);
            dec_use_imm      = 1'($urandom);
            dec_rs1_data     = $urandom;
            dec_rs2_data     = $urandom;
            dec_imm          = $urandom;
            exm_rd_we        = 1'($urandom);
            exm_rd_addr      = 5'($urandom_range(7, 0));
            exm_result       = $urandom;
            exm_load_pending = ($urandom_range(3, 0) == 0);
            wb_rd_we         = 1'($urandom);
            wb_rd_addr       = 5'($urandom_range(7, 0));
            wb_data          = $urandom;
            #1;
            n_cmp++; if (in_ready !== mdl_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, mdl_ready()); end
            cyc();
            n_cmp++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            n_cmp++; if (alu_rs1 !== m_rs1) begin n_fail++; $display("FAIL rnd_rs1[%0d] got %h exp %h", i, alu_rs1, m_rs1); end
            n_cmp++; if (alu_rs2 !== m_rs2) begin n_fail++; $display("FAIL rnd_rs2[%0d] got %h exp %h", i, alu_rs2, m_rs2); end
            n_cmp++; if (out_store_data !== m_sd) begin n_fail++; $display("FAIL rnd_sd[%0d] got %h exp %h", i, out_store_data, m_sd); end
            n_cmp++; if ({alu_op, out_rd_addr, out_rd_we} !== {m_op, m_rd, m_we}) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got %h/%h/%b exp %h/%h/%b", i, alu_op, out_rd_addr, out_rd_we, m_op, m_rd, m_we); end
            n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", i, stall_cnt, m_stall); end
        end
    endtask

    task automatic test_stall_saturate();
        set_idle();
        in_valid = 1; exm_load_pending = 1; exm_rd_we = 1; exm_rd_addr = 5'd7; dec_rs1_addr = 5'd7;
        for (int i = 0; i < 65540; i++) cyc();
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat got %h exp ffff", stall_cnt); end
        for (int i = 0; i < 4; i++) cyc();
        n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_nowrap got %h exp ffff", stall_cnt); end
    endtask

    task automatic test_imm_reset();
        set_idle();
        in_valid = 1; dec_use_imm = 1; dec_imm = 32'd16; dec_op = 4'b1000;
        dec_rs2_addr = 5'd9; dec_rs2_data = 32'h99; dec_rd_addr = 5'd2; dec_rd_we = 1;
        cyc();
        n_cmp++; if (alu_rs2 !== 32'd16) begin n_fail++; $display("FAIL imm_rs2 got %h exp 00000010", alu_rs2); end
        n_cmp++; if (alu_op !== 4'b1000) begin n_fail++; $display("FAIL imm_op got %h exp 8", alu_op); end
        n_cmp++; if (out_store_data !== 32'h99) begin n_fail++; $display("FAIL imm_store got %h exp 00000099", out_store_data); end
        n_cmp++; if ({out_rd_addr, out_rd_we} !== {5'd2, 1'b1}) begin n_fail++; $display("FAIL imm_rd got %h/%b exp 02/1", out_rd_addr, out_rd_we); end
        // Hold the entry in a stall, then reset: it must be dropped.
        set_idle();
        out_ready = 0; in_valid = 1; rst_n = 0; flush = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", in_ready); end
        cyc();
        n_cmp++; if ({out_valid, alu_rs1, alu_rs2, out_store_data, alu_op, out_rd_addr, out_rd_we} !== 107'h0) begin n_fail++; $display("FAIL rst_outputs got v%b %h %h %h %h %h %b exp 0", out_valid, alu_rs1, alu_rs2, out_store_data, alu_op, out_rd_addr, out_rd_we); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall got %0d exp 0", stall_cnt); end
        set_idle();
        cyc();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_forward_priority();
        test_x0_guard();
        test_held_refresh();
        test_flush();
        test_back_to_back();
        test_random();
        test_stall_saturate();
        test_imm_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 SHALL have ports: clk in 1, clock; all state updates on rising edge.
REQ-002 SHALL have rst_n in 1, reset, synchronous, active-low.
REQ-003 SHALL have in_valid in 1, decode presents an instruction; in_ready out 1, stage accepts it.
REQ-004 SHALL have dec_op in 4, dec_rs1_addr in 5, dec_rs2_addr in 5, dec_rd_addr in 5, dec_rd_we in 1, dec_use_imm in 1, dec_rs1_data in 32, dec_rs2_data in 32, dec_imm in 32; decoded fields and register-file read data.
REQ-005 SHALL have exm_rd_we in 1, exm_rd_addr in 5, exm_result in 32, exm_load_pending in 1; the EX/MEM stage's destination, its ALU result, and a load whose data is not yet available.
REQ-006 SHALL have wb_rd_we in 1, wb_rd_addr in 5, wb_data in 32; the writeback port.
REQ-007 SHALL have flush in 1, discard held and incoming instruction.
REQ-008 SHALL have out_valid out 1, out_ready in 1, alu_rs1 out 32, alu_rs2 out 32, alu_op out 4, out_rd_addr out 5, out_rd_we out 1, out_store_data out 32; these drive the ALU operand and op inputs directly.
REQ-009 SHALL have stall_cnt out 16, count of cycles with in_valid=1 and in_ready=0.

Function
REQ-010 SHALL hold at most one instruction; accept occurs when in_valid=1 and in_ready=1.
REQ-011 SHALL compute in_ready = (!out_valid or out_ready) and !hazard and !flush.
REQ-012 SHALL define hazard = in_valid and exm_load_pending and exm_rd_we and exm_rd_addr!=0 and (exm_rd_addr==dec_rs1_addr, or exm_rd_addr==dec_rs2_addr and (!dec_use_imm or dec_rd_we==0 store case, i.e. rs2 always considered)); rs2 match SHALL always count.
REQ-013 SHALL resolve each source operand at accept: exm match (exm_rd_we, addr nonzero, equal) -> exm_result; else wb match -> wb_data; else dec_rsN_data. EX/MEM SHALL take priority over WB.
REQ-014 SHALL never forward to source address 0; operand from address 0 SHALL be 32'h0 regardless of dec_rsN_data.
REQ-015 SHALL set alu_rs1 = resolved rs1; alu_rs2 = dec_imm if dec_use_imm else resolved rs2; out_store_data = resolved rs2 always.
REQ-016 SHALL register alu_op, out_rd_addr, out_rd_we from dec fields at accept; out_rd_we SHALL be forced 0 when dec_rd_addr==0.
REQ-017 SHALL, while out_valid=1 and out_ready=0, refresh held register-sourced operands (rs1, rs2 store data, alu_rs2 when not immediate) from wb_data when wb_rd_we=1, wb_rd_addr!=0 and equals the held source address.
REQ-018 SHALL set out_valid next cycle to 1 on accept; to 0 when out_ready=1 and no accept; unchanged otherwise.
REQ-019 SHALL support back-to-back accepts: out_ready=1 with in_valid=1 and no hazard replaces the entry with zero bubble.
REQ-020 SHALL, on flush=1, set out_valid=0 next cycle and ignore in_valid that cycle; flush SHALL override accept and WB refresh.
REQ-021 SHALL increment stall_cnt each cycle with in_valid=1 and in_ready=0, saturating at 16'hFFFF (no wrap).
REQ-022 SHALL leave held data fields unchanged when not accepting (except REQ-017); output latency accept-to-out_valid is 1 cycle.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, set out_valid=0, alu_rs1=alu_rs2=out_store_data=0, alu_op=0, out_rd_addr=0, out_rd_we=0, stall_cnt=0.
REQ-024 SHALL drive in_ready=0 while rst_n=0; reset SHALL take priority over flush and accept; an instruction held mid-stall SHALL be dropped.

Verification
REQ-025 Forwarding priority: dec_rs1_addr=5, exm_rd_addr=5 result 32'h0a17_0000, wb_rd_addr=5 data 32'h1111_1111, accept -> alu_rs1=32'h0a17_0000 next cycle.
REQ-026 x0 guard: dec_rs2_addr=0, dec_rs2_data=32'hdead_beef, exm_rd_addr=0 we=1 -> out_store_data=0, alu_rs2=0 (no imm).
REQ-027 Load-use: exm_load_pending=1, exm_rd_addr=7, dec_rs2_addr=7 for 3 cycles -> in_ready=0 3 cycles, stall_cnt=3, accept on cycle pending drops.
REQ-028 Held refresh: out_ready=0 holding rs1_addr=3, wb writes x3=32'hfa17_0000 -> alu_rs1=32'hfa17_0000 next cycle, out_valid stays 1.
REQ-029 Flush vs accept: out_valid=1, in_valid=1, out_ready=1, flush=1 -> out_valid=0 next cycle, alu_op unchanged.
REQ-030 Immediate/reset: dec_use_imm=1, dec_imm=32'd16, dec_op=4'b1000 -> alu_rs2=16, alu_op=4'b1000; then rst_n=0 one edge -> all outputs 0, stall_cnt=0.
